// File: rtl/mau_pkg.sv
// ============================================================================
// Module      : mau_pkg
// Description : Shared types, FSM state encodings and lane helpers for the
//               memory access unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mau_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_ILL  = 2'b11
    } size_e;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_RD_STB  = 3'd2;
    localparam logic [2:0] ST_RD_WAIT = 3'd3;
    localparam logic [2:0] ST_MERGE   = 3'd4;
    localparam logic [2:0] ST_WR_STB  = 3'd5;
    localparam logic [2:0] ST_WR_GAP  = 3'd6;
    localparam logic [2:0] ST_RESP    = 3'd7;

    // Little-endian lane pick, then sign- or zero-extend to a full word.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input size_e       size,
                                                 input logic        sgn);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        case (size)
            SIZE_BYTE: res = {{24{sgn & sh[7]}}, sh[7:0]};
            SIZE_HALF: res = {{16{sgn & sh[15]}}, sh[15:0]};
            default:   res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  off,
                                               input size_e       size);
        logic [4:0]  sh;
        logic [31:0] mask;
        logic [31:0] res;
        sh = {off, 3'b000};
        case (size)
            SIZE_BYTE: mask = 32'h0000_00FF << sh;
            SIZE_HALF: mask = 32'h0000_FFFF << sh;
            default:   mask = 32'hFFFF_FFFF;
        endcase
        res = (old_word & ~mask) | ((wdata << sh) & mask);
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mau_lane_align.sv
// ============================================================================
// Module      : mau_lane_align
// Description : Combinational load lane extract/extend and store lane merge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mau_lane_align
    import mau_pkg::*;
(
    input  logic [31:0] ld_word_i,
    input  logic [31:0] st_word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  offset_i,
    input  size_e       size_i,
    input  logic        signed_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_word_o
);

    assign ld_data_o = lane_extract(ld_word_i, offset_i, size_i, signed_i);
    assign st_word_o = lane_merge(st_word_i, wdata_i, offset_i, size_i);

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store initiator sequencing edge-triggered memRead/memWrite
//               strobes, with read-modify-write for sub-word stores.
//               Define MAU_MISALIGN_TRAP_EN to trap misaligned half/word access.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 1024,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

    logic [2:0]        state_q, state_d;
    logic              ready_q, ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rd_word_q, rd_word_d;
    logic              write_q, write_d;
    size_e             size_q, size_d;
    logic              signed_q, signed_d;
    logic [1:0]        off_q, off_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [ADDR_W-1:0] w_idx;
    size_e             w_size;
    logic              w_misalign;
    logic              w_err;
    logic [1:0]        w_off;
    logic [DATA_W-1:0] w_ld_data;
    logic [DATA_W-1:0] w_st_word;

    assign w_idx  = {2'b00, req_addr[ADDR_W-1:2]};
    assign w_size = size_e'(req_size);

`ifdef MAU_MISALIGN_TRAP_EN
    assign w_misalign = ((w_size == SIZE_HALF) && req_addr[0]) ||
                        ((w_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err = (w_size == SIZE_ILL) || (w_idx >= ADDR_W'(MEM_WORDS)) || w_misalign;

    // Offending low bits are dropped so half/word accesses land on their lane.
    always_comb begin
        case (w_size)
            SIZE_HALF: w_off = {req_addr[1], 1'b0};
            SIZE_WORD: w_off = 2'b00;
            default:   w_off = req_addr[1:0];
        endcase
    end

    mau_lane_align u_lane_align (
        .ld_word_i (mem_readdata),
        .st_word_i (rd_word_q),
        .wdata_i   (wdata_q),
        .offset_i  (off_q),
        .size_i    (size_q),
        .signed_i  (signed_q),
        .ld_data_o (w_ld_data),
        .st_word_o (w_st_word)
    );

    always_comb begin
        state_d      = state_q;
        ready_d      = ready_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_word_d    = rd_word_q;
        write_d      = write_q;
        size_d       = size_q;
        signed_d     = signed_q;
        off_d        = off_q;
        cnt_d        = cnt_q;
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (req_valid && ready_q) begin
                    ready_d  = 1'b0;
                    write_d  = req_write;
                    size_d   = w_size;
                    signed_d = req_signed;
                    off_d    = w_off;
                    if (w_err) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d = ST_SETUP;
                        addr_d  = w_idx;
                        if (req_write) begin
                            wdata_d = req_wdata;
                        end
                    end
                end
            end
            ST_SETUP: begin
                if (write_q && (size_q == SIZE_WORD)) begin
                    state_d     = ST_WR_STB;
                    mem_write_d = 1'b1;
                end else begin
                    state_d    = ST_RD_STB;
                    mem_read_d = 1'b1;
                end
            end
            ST_RD_STB: begin
                state_d = ST_RD_WAIT;
                cnt_d   = CNT_INIT;
            end
            ST_RD_WAIT: begin
                if (cnt_q == '0) begin
                    if (write_q) begin
                        rd_word_d = mem_readdata;
                        state_d   = ST_MERGE;
                    end else begin
                        resp_rdata_d = w_ld_data;
                        resp_valid_d = 1'b1;
                        state_d      = ST_RESP;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_MERGE: begin
                wdata_d     = w_st_word;
                mem_write_d = 1'b1;
                state_d     = ST_WR_STB;
            end
            ST_WR_STB: state_d = ST_WR_GAP;
            ST_WR_GAP: begin
                resp_valid_d = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_word_q    <= '0;
            write_q      <= 1'b0;
            size_q       <= SIZE_BYTE;
            signed_q     <= 1'b0;
            off_q        <= 2'b00;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_word_q    <= rd_word_d;
            write_q      <= write_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            off_q        <= off_d;
            cnt_q        <= cnt_d;
        end
    end

    assign req_ready     = ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_err      = resp_err_q;
    assign resp_rdata    = resp_rdata_q;
    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_address   = addr_q;
    assign mem_writedata = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Scoreboard bench for mem_access_unit with a behavioural
//               edge-triggered data memory and strobe monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_writedata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_readdata = '0;

    mem_access_unit #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MEM_WORDS (1024),
        .RD_LAT    (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_size      (req_size),
        .req_signed    (req_signed),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_readdata  (mem_readdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          ncyc;
        int          nrd;
        int          nwr;
        int          acc;
        int          rdb;
        int          wrb;
        string       nm;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem [0:1023];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_rd = 0;
    int          n_wr = 0;
    logic        rd_prev = 1'b0;
    logic        wr_prev = 1'b0;
    logic [31:0] cur_widx = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
        end
    endtask

    // Memory model reacts to strobe rising edges; also polices strobe shape.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (mem_read || mem_write) begin
                    chk("strobe_overlap", 32'(mem_read & mem_write), 32'd0);
                    chk("strobe_consecutive", 32'(rd_prev | wr_prev), 32'd0);
                    chk("strobe_addr", mem_address, cur_widx);
                end
                if (rd_prev || wr_prev) chk("addr_after_strobe", mem_address, cur_widx);
                if (mem_write && !wr_prev) begin
                    n_wr++;
                    if (mem_address < 32'd1024) mem[mem_address[9:0]] = mem_writedata;
                end
                if (mem_read && !rd_prev) begin
                    n_rd++;
                    if (mem_address < 32'd1024) mem_readdata = mem[mem_address[9:0]];
                end
                if (resp_valid) begin
                    if (q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_resp: got resp_valid=1 required no response");
                    end else begin
                        e = q.pop_front();
                        chk({e.nm, "_rdata"}, resp_rdata, e.rdata);
                        chk({e.nm, "_err"}, 32'(resp_err), 32'(e.err));
                        chk({e.nm, "_cycle"}, 32'(cyc - e.acc + 1), 32'(e.ncyc));
                        chk({e.nm, "_reads"}, 32'(n_rd - e.rdb), 32'(e.nrd));
                        chk({e.nm, "_writes"}, 32'(n_wr - e.wrb), 32'(e.nwr));
                    end
                end
            end
            rd_prev = mem_read;
            wr_prev = mem_write;
        end
    endtask

    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] erd, input logic eerr, input int ncyc,
                         input int nrd, input int nwr, input string nm, input bit track);
        exp_t e;
        int   i;
        i = 0;
        while (!req_ready && i < 50) begin
            @(negedge clk);
            i++;
        end
        if (!req_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_ready_timeout: got req_ready=0 required 1", nm);
        end
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        cur_widx   = addr >> 2;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (track) begin
            e.rdata = erd;
            e.err   = eerr;
            e.ncyc  = ncyc;
            e.nrd   = nrd;
            e.nwr   = nwr;
            e.acc   = cyc;
            e.rdb   = n_rd;
            e.wrb   = n_wr;
            e.nm    = nm;
            q.push_back(e);
            i = 0;
            while (q.size() != 0 && i < 50) begin
                @(negedge clk);
                i++;
            end
            if (q.size() != 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s_resp_timeout: got no resp_valid required one", nm);
                q.delete();
            end
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctrl"}, 32'({req_ready, resp_valid, resp_err, mem_read, mem_write}), 32'd0);
        chk({nm, "_rdata"}, resp_rdata, 32'd0);
        chk({nm, "_addr"}, mem_address, 32'd0);
        chk({nm, "_wdata"}, mem_writedata, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        fork
            monitor();
        join_none

        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 4, 0, 1, "st_word", 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 4, 1, 0, "ld_word", 1'b1);

        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0, 4, 0, 1, "st_word2", 1'b1);
        issue(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA, 32'h0, 1'b0, 7, 1, 1, "st_byte", 1'b1);
        chk("mem_after_byte_store", mem[4], 32'h11AA3344);
        issue(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 32'hFFFFFFAA, 1'b0, 4, 1, 0, "ld_byte_s", 1'b1);
        issue(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 32'h000000AA, 1'b0, 4, 1, 0, "ld_byte_u", 1'b1);
        issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h00000011, 1'b0, 4, 1, 0, "ld_byte3_s", 1'b1);

        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h80013344, 32'h0, 1'b0, 4, 0, 1, "st_word3", 1'b1);
        issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFF8001, 1'b0, 4, 1, 0, "ld_half_s", 1'b1);
        issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h00008001, 1'b0, 4, 1, 0, "ld_half_u", 1'b1);
        issue(1'b1, 2'b01, 1'b0, 32'h10, 32'h00005566, 32'h0, 1'b0, 7, 1, 1, "st_half", 1'b1);
        chk("mem_after_half_store", mem[4], 32'h80015566);

        issue(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1, 1, 0, 0, "err_range_ld", 1'b1);
        issue(1'b1, 2'b10, 1'b0, 32'h1000, 32'h12345678, 32'h0, 1'b1, 1, 0, 0, "err_range_st", 1'b1);
        issue(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1, 1, 0, 0, "err_size", 1'b1);
        issue(1'b1, 2'b10, 1'b0, 32'hFFC, 32'hCAFEF00D, 32'h0, 1'b0, 4, 0, 1, "st_last", 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, 32'hCAFEF00D, 1'b0, 4, 1, 0, "ld_last", 1'b1);

`ifdef MAU_MISALIGN_TRAP_EN
        issue(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1, 0, 0, "ld_misalign_w", 1'b1);
        issue(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 1, 0, 0, "ld_misalign_h", 1'b1);
`else
        issue(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'h80015566, 1'b0, 4, 1, 0, "ld_misalign_w", 1'b1);
        issue(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'h00005566, 1'b0, 4, 1, 0, "ld_misalign_h", 1'b1);
`endif

        // Abort a load in RD_WAIT: cycle 1 and 2 negedges, then RD_WAIT's.
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 0, 0, 0, "ld_abort", 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk_zero("midop_reset");
        end
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_midop_reset", 32'(req_ready), 32'd1);
        chk("no_resp_after_midop_reset", 32'(resp_valid), 32'd0);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80015566, 1'b0, 4, 1, 0, "ld_post_reset", 1'b1);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
